// File: rtl/motion_pkg.sv
// Shared motion-control types: period width, controller states and profile phases.
// Also used by the parameter calculation stage.
package motion_pkg;

    localparam int PERIOD_W = 32;

    typedef enum logic [1:0] {IDLE, PULSE, WAIT, FINISH} state_t;
    typedef enum logic [1:0] {ACCEL, CRUISE, DECEL} phase_t;

    // a - b, never dropping below floor and never wrapping
    function automatic logic [PERIOD_W-1:0] sat_sub(input logic [PERIOD_W-1:0] a,
                                                    input logic [PERIOD_W-1:0] b,
                                                    input logic [PERIOD_W-1:0] floor);
        if (a < b || (a - b) < floor) return floor;
        return a - b;
    endfunction

    // a + b, never exceeding ceil and never wrapping
    function automatic logic [PERIOD_W-1:0] sat_add(input logic [PERIOD_W-1:0] a,
                                                    input logic [PERIOD_W-1:0] b,
                                                    input logic [PERIOD_W-1:0] ceil);
        logic [PERIOD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, ceil}) return ceil;
        return sum[PERIOD_W-1:0];
    endfunction

endpackage

// File: rtl/step_profile_generator.sv
// Trapezoidal step pulse generator for one axis: accel, cruise, mirrored decel.
// Loaded once per move from the parameter calculation stage.
//
// state  | meaning
// IDLE   | waiting for load
// PULSE  | step high for PULSE_W cycles
// WAIT   | step low for the rest of the period
// FINISH | end of move; done pulse (zero-step moves spend one extra busy cycle here)
module step_profile_generator
    import motion_pkg::*;
#(
    parameter int PULSE_W    = 4,
    parameter int MIN_PERIOD = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                abort,
    input  logic [PERIOD_W-1:0] steps,
    input  logic [PERIOD_W-1:0] accel_steps,
    input  logic [PERIOD_W-1:0] start_period,
    input  logic [PERIOD_W-1:0] cruise_period,
    input  logic [PERIOD_W-1:0] delta,
    output logic                step,
    output logic                busy,
    output logic                done,
    output logic [PERIOD_W-1:0] step_count,
    output logic [PERIOD_W-1:0] cur_period
);

    localparam logic [PERIOD_W-1:0] PW   = PERIOD_W'(PULSE_W);
    localparam logic [PERIOD_W-1:0] PMIN = PERIOD_W'(MIN_PERIOD);

    state_t state, state_next;
    phase_t phase;

    logic [PERIOD_W-1:0] s_steps, s_accel, s_start, s_cruise, s_delta;
    logic [PERIOD_W-1:0] cnt, p_reg, accel_used, saved;
    logic                in_decel, zero_pend;

    logic accept, period_end, last_step, advance;

    logic [PERIOD_W-1:0] d_steps, d_accel, d_start, d_cruise, d_delta;
    logic [PERIOD_W-1:0] d_p, d_used, d_saved, d_cnt, remaining;
    logic [PERIOD_W-1:0] use_p, np, nused, nsaved, eff;
    logic                d_in_decel;

    assign accept     = (state == IDLE) && load && !abort;
    assign period_end = (state == WAIT) && (cnt == '0) && !abort;
    assign last_step  = (step_count + 32'd1) == s_steps;
    assign advance    = (accept && steps != '0) || (period_end && !last_step);

    assign step = (state == PULSE);
    assign busy = (state == PULSE) || (state == WAIT) || (state == FINISH && zero_pend);
    assign done = (state == FINISH) && !zero_pend;

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (load) state_next = (steps == '0) ? FINISH : PULSE;
                PULSE:   if (cnt == cur_period - PW) state_next = WAIT;
                WAIT:    if (cnt == '0) state_next = last_step ? FINISH : PULSE;
                FINISH:  if (!zero_pend) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Phase decision for the next step; on load it works from the live inputs
    always_comb begin
        d_steps    = accept ? steps         : s_steps;
        d_accel    = accept ? accel_steps   : s_accel;
        d_start    = accept ? start_period  : s_start;
        d_cruise   = accept ? cruise_period : s_cruise;
        d_delta    = accept ? delta         : s_delta;
        d_p        = accept ? ((accel_steps == '0) ? cruise_period : start_period) : p_reg;
        d_used     = accept ? '0 : accel_used;
        d_saved    = accept ? '0 : saved;
        d_in_decel = accept ? 1'b0 : in_decel;
        d_cnt      = accept ? '0 : step_count + 32'd1;
        remaining  = d_steps - d_cnt;

        phase  = CRUISE;
        use_p  = d_cruise;
        np     = d_cruise;
        nused  = d_used;
        nsaved = d_saved;
        if (remaining <= d_used) begin
            phase = DECEL;
            use_p = d_in_decel ? sat_add(d_p, d_delta, d_start) : d_saved;
            np    = use_p;
        end else if (d_used < d_accel && d_p > d_cruise) begin
            phase  = ACCEL;
            use_p  = d_p;
            np     = sat_sub(d_p, d_delta, d_cruise);
            nused  = d_used + 32'd1;
            nsaved = d_p;
        end
        eff = (use_p < PMIN) ? PMIN : use_p;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_steps    <= '0;
            s_accel    <= '0;
            s_start    <= '0;
            s_cruise   <= '0;
            s_delta    <= '0;
            cnt        <= '0;
            p_reg      <= '0;
            accel_used <= '0;
            saved      <= '0;
            in_decel   <= 1'b0;
            zero_pend  <= 1'b0;
            step_count <= '0;
            cur_period <= '0;
        end else if (abort) begin
            zero_pend <= 1'b0;
        end else begin
            if (accept) begin
                s_steps    <= steps;
                s_accel    <= accel_steps;
                s_start    <= start_period;
                s_cruise   <= cruise_period;
                s_delta    <= delta;
                step_count <= '0;
                zero_pend  <= (steps == '0);
            end
            if (advance) begin
                cnt        <= eff - 32'd1;
                cur_period <= eff;
                p_reg      <= np;
                accel_used <= nused;
                saved      <= nsaved;
                in_decel   <= (phase == DECEL);
            end else if (state == PULSE || (state == WAIT && cnt != '0)) begin
                cnt <= cnt - 32'd1;
            end
            if (period_end) step_count <= step_count + 32'd1;
            if (state == FINISH) zero_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_step_profile_generator.sv
// Directed bench for step_profile_generator: profiles, zero-step move, abort, reload, reset.
module tb_step_profile_generator;

    logic        clk = 1'b0;
    logic        reset, load, abort;
    logic [31:0] steps, accel_steps, start_period, cruise_period, delta;
    logic        step, busy, done;
    logic [31:0] step_count, cur_period;

    int n_checks = 0;
    int n_errors = 0;

    int rise_t [32];
    int rise_cp[32];
    int n_rise, done_at, high_cnt, busy_cnt;
    logic ab_step, ab_busy;

    always #5 clk = ~clk;

    step_profile_generator #(.PULSE_W(4), .MIN_PERIOD(8)) dut (
        .clk(clk), .reset(reset), .load(load), .abort(abort),
        .steps(steps), .accel_steps(accel_steps), .start_period(start_period),
        .cruise_period(cruise_period), .delta(delta),
        .step(step), .busy(busy), .done(done),
        .step_count(step_count), .cur_period(cur_period)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycle n=1 is the cycle after the load cycle; samples are taken 1 time unit after each edge.
    task automatic run_move(input logic [31:0] s, input logic [31:0] a, input logic [31:0] sp,
                            input logic [31:0] cp, input logic [31:0] dl, input int budget,
                            input int abort_at, input int reload_at);
        logic prev;
        n_rise = 0; done_at = -1; high_cnt = 0; busy_cnt = 0;
        ab_step = 1'b1; ab_busy = 1'b1;
        steps = s; accel_steps = a; start_period = sp; cruise_period = cp; delta = dl;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        prev = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            if (n > 1) begin @(posedge clk); #1; end
            load = 1'b0;
            abort = 1'b0;
            if (step && !prev && n_rise < 32) begin
                rise_t[n_rise] = n;
                rise_cp[n_rise] = int'(cur_period);
                n_rise++;
            end
            prev = step;
            if (step) high_cnt++;
            if (busy) busy_cnt++;
            if (n == abort_at + 1) begin ab_step = step; ab_busy = busy; end
            if (done) begin done_at = n; break; end
            if (n == abort_at) abort = 1'b1;
            if (n == reload_at) begin
                load = 1'b1; steps = 32'd2; start_period = 32'd10; accel_steps = 32'd0;
            end
        end
    endtask

    task automatic check_profile(input string tag, input int exp_q[$], input int exp_done);
        int obs;
        check({tag, "_nrise"}, n_rise, exp_q.size());
        check({tag, "_first"}, rise_t[0], 1);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < n_rise - 1)       obs = rise_t[i+1] - rise_t[i];
            else if (i == n_rise - 1) obs = done_at - rise_t[i];
            else                      obs = 0;
            check($sformatf("%s_per%0d", tag, i), obs, exp_q[i]);
            check($sformatf("%s_cur%0d", tag, i), (i < n_rise) ? rise_cp[i] : 0, exp_q[i]);
        end
        check({tag, "_done_at"}, done_at, exp_done);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_count"}, step_count, exp_q.size());
        check({tag, "_high"}, high_cnt, 4 * exp_q.size());
    endtask

    initial begin
        int prof1[$], prof2[$], prof4[$];
        int hi;
        prof1 = '{100, 80, 60, 40, 40, 40, 40, 60, 80, 100};
        prof2 = '{100, 80, 80, 100};
        prof4 = '{8, 8, 8, 8, 8};

        reset = 1'b1; load = 1'b0; abort = 1'b0;
        steps = '0; accel_steps = '0; start_period = '0; cruise_period = '0; delta = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_step", step, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_count", step_count, 0);
        check("rst_period", cur_period, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Full trapezoid
        run_move(10, 3, 100, 40, 20, 800, -1, -1);
        check_profile("trap10", prof1, 641);
        check("trap10_busy_cycles", busy_cnt, 640);
        @(posedge clk); #1;
        check("trap10_idle_done", done, 1'b0);

        // Triangle: no cruise phase
        run_move(4, 3, 100, 40, 20, 500, -1, -1);
        check_profile("tri4", prof2, 361);
        @(posedge clk); #1;

        // Zero-step move
        run_move(0, 3, 100, 40, 20, 10, -1, -1);
        check("zero_nrise", n_rise, 0);
        check("zero_done_at", done_at, 2);
        check("zero_busy_cycles", busy_cnt, 1);
        @(posedge clk); #1;

        // Cruise below the period floor
        run_move(5, 0, 100, 3, 20, 100, -1, -1);
        check_profile("floor5", prof4, 41);
        @(posedge clk); #1;

        // Abort during the pulse of the 3rd step (rises at cycle 181)
        run_move(10, 3, 100, 40, 20, 400, 182, -1);
        check("abort_nrise", n_rise, 3);
        check("abort_step_next", ab_step, 1'b0);
        check("abort_busy_next", ab_busy, 1'b0);
        check("abort_no_done", done_at, -1);
        check("abort_count", step_count, 2);
        check("abort_busy_end", busy, 1'b0);

        // Reload while busy is ignored
        run_move(10, 3, 100, 40, 20, 800, -1, 50);
        check_profile("reload", prof1, 641);
        @(posedge clk); #1;

        // load and abort together: load dropped
        steps = 10; accel_steps = 3; start_period = 100; cruise_period = 40; delta = 20;
        load = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; abort = 1'b0;
        hi = 0;
        check("ldab_busy", busy, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (step || busy) hi++;
            @(posedge clk); #1;
        end
        check("ldab_quiet", hi, 0);

        // Reset mid-move
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (120) @(posedge clk);
        #1;
        check("mid_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_step", step, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_done", done, 1'b0);
        check("mid_count", step_count, 0);
        check("mid_period", cur_period, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_stays_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
